// File: rtl/kvs_req_arbiter_if.sv
// Bundles the two requester ports, the database lookup port and status for kvs_req_arbiter.
// slave = arbiter view, master = view of the surrounding Ethernet/database logic.
interface kvs_req_arbiter_if #(
    parameter int KEY_SIZE  = 96,
    parameter int FLAG_SIZE = 4,
    parameter int TAG_AW    = 3
);
    logic [KEY_SIZE-1:0]  req0_key;
    logic [FLAG_SIZE-1:0] req0_flag;
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 rsp0_valid;
    logic [FLAG_SIZE-1:0] rsp0_flag;

    logic [KEY_SIZE-1:0]  req1_key;
    logic [FLAG_SIZE-1:0] req1_flag;
    logic                 req1_valid;
    logic                 req1_ready;
    logic                 rsp1_valid;
    logic [FLAG_SIZE-1:0] rsp1_flag;

    logic [KEY_SIZE-1:0]  db_key;
    logic [FLAG_SIZE-1:0] db_flag;
    logic                 db_valid;
    logic                 db_ready;
    logic                 db_out_valid;
    logic [FLAG_SIZE-1:0] db_out_flag;

    logic [TAG_AW:0]      outstanding;
    logic                 err_orphan;

    modport slave (
        input  req0_key, req0_flag, req0_valid,
        output req0_ready, rsp0_valid, rsp0_flag,
        input  req1_key, req1_flag, req1_valid,
        output req1_ready, rsp1_valid, rsp1_flag,
        output db_key, db_flag, db_valid,
        input  db_ready, db_out_valid, db_out_flag,
        output outstanding, err_orphan
    );

    modport master (
        output req0_key, req0_flag, req0_valid,
        input  req0_ready, rsp0_valid, rsp0_flag,
        output req1_key, req1_flag, req1_valid,
        input  req1_ready, rsp1_valid, rsp1_flag,
        input  db_key, db_flag, db_valid,
        output db_ready, db_out_valid, db_out_flag,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/kvs_req_arbiter.sv
// Two-port round-robin arbiter onto the KVS lookup port; an in-order tag FIFO steers responses
// back to their issuer. Define KVS_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module kvs_req_arbiter #(
    parameter int KEY_SIZE  = 96,
    parameter int FLAG_SIZE = 4,
    parameter int TAG_DEPTH = 8,
    parameter int TAG_AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    kvs_req_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_e;

    localparam logic [TAG_AW:0] FULL = (TAG_AW+1)'(TAG_DEPTH);

    state_e               state_q, state_d;
    logic [TAG_AW:0]      count_q, count_d;
    logic [TAG_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 tag_mem_q [TAG_DEPTH];
    logic                 gnt_port_q, gnt_port_d;
    logic [KEY_SIZE-1:0]  key_q, key_d;
    logic [FLAG_SIZE-1:0] flag_q, flag_d;
    logic                 rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
    logic [FLAG_SIZE-1:0] rsp0_flag_q, rsp0_flag_d, rsp1_flag_q, rsp1_flag_d;
    logic                 err_q, err_d;
    logic                 can_grant, winner, push, pop, head;

`ifdef KVS_ARB_FIXED_PRIO_EN
    assign winner = ~bus.req0_valid;
`else
    logic last_q, last_d;
    // On a tie, the port that did not win last time goes next.
    assign winner = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
`endif

    assign can_grant = (state_q == IDLE) && (count_q != FULL) && (bus.req0_valid || bus.req1_valid);
    assign push      = (state_q == ISSUE) && bus.db_ready;
    assign pop       = bus.db_out_valid && (count_q != '0);
    assign head      = tag_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        gnt_port_d  = gnt_port_q;
        key_d       = key_q;
        flag_d      = flag_q;
        rsp0_vld_d  = 1'b0;
        rsp1_vld_d  = 1'b0;
        rsp0_flag_d = rsp0_flag_q;
        rsp1_flag_d = rsp1_flag_q;
        err_d       = err_q;
`ifndef KVS_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (can_grant) begin
                    state_d    = ISSUE;
                    gnt_port_d = winner;
                    key_d      = winner ? bus.req1_key  : bus.req0_key;
                    flag_d     = winner ? bus.req1_flag : bus.req0_flag;
                end
            end
            ISSUE: begin
                if (bus.db_ready) begin
                    state_d  = IDLE;
                    wr_ptr_d = wr_ptr_q + 1'b1;
`ifndef KVS_ARB_FIXED_PRIO_EN
                    last_d   = gnt_port_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head) begin
                rsp1_vld_d  = 1'b1;
                rsp1_flag_d = bus.db_out_flag;
            end else begin
                rsp0_vld_d  = 1'b1;
                rsp0_flag_d = bus.db_out_flag;
            end
        end
        if (bus.db_out_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gnt_port_q  <= 1'b0;
            key_q       <= '0;
            flag_q      <= '0;
            rsp0_vld_q  <= 1'b0;
            rsp1_vld_q  <= 1'b0;
            rsp0_flag_q <= '0;
            rsp1_flag_q <= '0;
            err_q       <= 1'b0;
`ifndef KVS_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            gnt_port_q  <= gnt_port_d;
            key_q       <= key_d;
            flag_q      <= flag_d;
            rsp0_vld_q  <= rsp0_vld_d;
            rsp1_vld_q  <= rsp1_vld_d;
            rsp0_flag_q <= rsp0_flag_d;
            rsp1_flag_q <= rsp1_flag_d;
            err_q       <= err_d;
`ifndef KVS_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    // Tag storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_port_q;
        end
    end

    assign bus.req0_ready  = can_grant && !winner;
    assign bus.req1_ready  = can_grant && winner;
    assign bus.db_valid    = (state_q == ISSUE);
    assign bus.db_key      = key_q;
    assign bus.db_flag     = flag_q;
    assign bus.rsp0_valid  = rsp0_vld_q;
    assign bus.rsp0_flag   = rsp0_flag_q;
    assign bus.rsp1_valid  = rsp1_vld_q;
    assign bus.rsp1_flag   = rsp1_flag_q;
    assign bus.outstanding = count_q;
    assign bus.err_orphan  = err_q;
endmodule

// File: tb/tb_kvs_req_arbiter.sv
// Directed bench for kvs_req_arbiter: grant order, stall, full FIFO, response steering, orphans, reset.
module tb_kvs_req_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_p;
    int   prev_p;

    localparam logic [95:0] K0 = 96'hA0;
    localparam logic [95:0] K1 = 96'hB1;
    localparam logic [95:0] K2 = 96'hDEAD_BEEF_0123_4567;

    kvs_req_arbiter_if #(.KEY_SIZE(96), .FLAG_SIZE(4), .TAG_AW(3)) bus ();

    kvs_req_arbiter #(.KEY_SIZE(96), .FLAG_SIZE(4), .TAG_DEPTH(8), .TAG_AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        prev_p = 0;
        rst_n = 1'b0;
        bus.req0_key = '0; bus.req0_flag = '0; bus.req0_valid = 1'b0;
        bus.req1_key = '0; bus.req1_flag = '0; bus.req1_valid = 1'b0;
        bus.db_ready = 1'b0; bus.db_out_valid = 1'b0; bus.db_out_flag = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_db_valid", bus.db_valid, 0);
        chk("rst_db_key", bus.db_key, 0);
        chk("rst_db_flag", bus.db_flag, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_err", bus.err_orphan, 0);
        chk("rst_rsp0", {bus.rsp0_valid, bus.rsp0_flag}, 0);
        chk("rst_rsp1", {bus.rsp1_valid, bus.rsp1_flag}, 0);
        rst_n = 1'b1;

        // Single request on port 0
        bus.req0_key = 96'h1; bus.req0_flag = 4'h1; bus.req0_valid = 1'b1; bus.db_ready = 1'b1;
        #1;
        chk("t1_rdy0", bus.req0_ready, 1);
        chk("t1_rdy1", bus.req1_ready, 0);
        cyc(); bus.req0_valid = 1'b0; #1;
        chk("t1_db_valid", bus.db_valid, 1);
        chk("t1_db_key", bus.db_key, 96'h1);
        chk("t1_db_flag", bus.db_flag, 4'h1);
        chk("t1_rdy0_off", bus.req0_ready, 0);
        chk("t1_out0", bus.outstanding, 0);
        cyc(); #1;
        chk("t1_out1", bus.outstanding, 1);
        chk("t1_db_idle", bus.db_valid, 0);
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h3;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t1_rsp0_vld", bus.rsp0_valid, 1);
        chk("t1_rsp0_flag", bus.rsp0_flag, 4'h3);
        chk("t1_rsp1_vld", bus.rsp1_valid, 0);
        chk("t1_out_pop", bus.outstanding, 0);
        cyc(); #1;
        chk("t1_rsp0_drop", bus.rsp0_valid, 0);
        chk("t1_rsp0_hold", bus.rsp0_flag, 4'h3);

        // Both ports valid; last grant was port 0
        bus.req0_key = K0; bus.req0_flag = 4'h2; bus.req0_valid = 1'b1;
        bus.req1_key = K1; bus.req1_flag = 4'h4; bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.db_out_valid = (i > 0);
            bus.db_out_flag  = 4'(8 + i);
            #1;
`ifdef KVS_ARB_FIXED_PRIO_EN
            exp_p = 0;
`else
            exp_p = (i % 2 == 0) ? 1 : 0;
`endif
            chk("t2_rdy0", bus.req0_ready, (exp_p == 0));
            chk("t2_rdy1", bus.req1_ready, (exp_p == 1));
            cyc(); bus.db_out_valid = 1'b0; #1;
            chk("t2_db_key", bus.db_key, (exp_p == 1) ? K1 : K0);
            if (i > 0) begin
                chk("t2_rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, (prev_p == 1) ? 2'b10 : 2'b01);
                chk("t2_rsp_flag", (prev_p == 1) ? bus.rsp1_flag : bus.rsp0_flag, 8 + i);
            end
            prev_p = exp_p;
            cyc();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'hC;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t2_last_rsp", {bus.rsp1_valid, bus.rsp0_valid}, (prev_p == 1) ? 2'b10 : 2'b01);
        chk("t2_out_drained", bus.outstanding, 0);

        // Database stalls for 5 cycles
        bus.req1_key = K2; bus.req1_flag = 4'h5; bus.req1_valid = 1'b1; bus.db_ready = 1'b0;
        #1;
        chk("t3_rdy1", bus.req1_ready, 1);
        cyc(); bus.req1_valid = 1'b0; bus.req0_valid = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_db_valid", bus.db_valid, 1);
            chk("t3_db_key", bus.db_key, K2);
            chk("t3_db_flag", bus.db_flag, 4'h5);
            chk("t3_no_rdy0", bus.req0_ready, 0);
            chk("t3_out", bus.outstanding, 0);
            cyc(); #1;
        end
        bus.db_ready = 1'b1; bus.req0_valid = 1'b0;
        cyc(); #1;
        chk("t3_out_once", bus.outstanding, 1);
        chk("t3_db_idle", bus.db_valid, 0);
        cyc(); #1;
        chk("t3_out_still", bus.outstanding, 1);
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h6;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t3_rsp1", {bus.rsp1_valid, bus.rsp1_flag}, {1'b1, 4'h6});
        chk("t3_rsp0", bus.rsp0_valid, 0);
        chk("t3_out_pop", bus.outstanding, 0);

        // Fill the tag FIFO
        bus.req0_key = K0; bus.req0_valid = 1'b1; bus.db_ready = 1'b1;
        repeat (16) cyc();
        #1;
        chk("t4_full", bus.outstanding, 8);
        chk("t4_full_rdy0", bus.req0_ready, 0);
        chk("t4_full_db", bus.db_valid, 0);
        cyc(); #1;
        chk("t4_full_rdy0b", bus.req0_ready, 0);
        chk("t4_full_hold", bus.outstanding, 8);
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h7;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t4_out7", bus.outstanding, 7);
        chk("t4_rsp0", {bus.rsp0_valid, bus.rsp0_flag}, {1'b1, 4'h7});
        chk("t4_regrant", bus.req0_ready, 1);
        cyc(); bus.req0_valid = 1'b0; bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h1; #1;
        chk("t4_issue", bus.db_valid, 1);
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t4_pushpop", bus.outstanding, 7);
        chk("t4_pushpop_rsp", bus.rsp0_valid, 1);
        bus.db_out_valid = 1'b1;
        repeat (7) cyc();
        bus.db_out_valid = 1'b0; #1;
        chk("t4_drained", bus.outstanding, 0);
        chk("t4_no_err", bus.err_orphan, 0);

        // Orphan response, then reset while issuing
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h9;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t5_orphan_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("t5_err_set", bus.err_orphan, 1);
        chk("t5_out", bus.outstanding, 0);
        cyc(); #1;
        chk("t5_err_sticky", bus.err_orphan, 1);
        bus.req0_valid = 1'b1; bus.db_ready = 1'b1;
        cyc(); cyc(); bus.db_ready = 1'b0;
        cyc(); bus.req0_valid = 1'b0; #1;
        chk("t5_pre_issue", bus.db_valid, 1);
        chk("t5_pre_out", bus.outstanding, 1);
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1; #1;
        chk("t5_rst_db", bus.db_valid, 0);
        chk("t5_rst_out", bus.outstanding, 0);
        chk("t5_rst_err", bus.err_orphan, 0);
        bus.db_ready = 1'b1; bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h2;
        cyc(); bus.db_out_valid = 1'b0; #1;
        chk("t5_post_orphan", bus.err_orphan, 1);
        chk("t5_post_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kvs_req_arbiter.md
Name: kvs_req_arbiter

Overview:
- Shares the single KVS lookup interface of the database block (key/flag request, flag response) between two Ethernet-side requesters: port 0 = ETH0 path, port 1 = ETH1 path.
- Arbitrates requests round-robin and holds the request on the database side until accepted.
- Records the owner of every issued request in an in-order tag FIFO, then steers each database response back to the requester that issued it.
- Sits in the db_clk domain, between the Ethernet top and the database top.

Parameters:
- KEY_SIZE, 96, key width in bits.
- FLAG_SIZE, 4, request/response flag width.
- TAG_DEPTH, 8, max outstanding requests; power of two, >= 2.
- TAG_AW, 3, log2(TAG_DEPTH).

Ports:
- clk  in  1  db_clk; every register is updated on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_key  in  KEY_SIZE  port 0 key.
- req0_flag  in  FLAG_SIZE  port 0 request flag.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response strobe, 1 cycle.
- rsp0_flag  out  FLAG_SIZE  port 0 response flag.
- req1_key, req1_flag, req1_valid, req1_ready, rsp1_valid, rsp1_flag  same as port 0, for port 1.
- db_key  out  KEY_SIZE  key to the database.
- db_flag  out  FLAG_SIZE  flag to the database.
- db_valid  out  1  request valid to the database.
- db_ready  in  1  database accepts the request.
- db_out_valid  in  1  database response strobe.
- db_out_flag  in  FLAG_SIZE  database response flag.
- outstanding  out  TAG_AW+1  tag FIFO occupancy.
- err_orphan  out  1  sticky: a response arrived with no outstanding tag.

Behaviour:
- Reset, synchronous on rst_n=0:
  - all outputs 0, db_key and db_flag included;
  - FIFO pointers and count cleared; last-grant pointer = 1, so port 0 wins first;
  - FSM = IDLE.
- FSM states:
  - IDLE: db_valid=0.
  - ISSUE: db_valid=1; db_key and db_flag held stable.
- IDLE -> ISSUE: requires at least one reqN_valid and outstanding < TAG_DEPTH.
  - Winner: round-robin. If both ports are valid, grant the port other than the last grant; otherwise grant the single valid port.
  - reqN_ready=1 for exactly that cycle (combinational from FSM state, count and valids).
  - Key and flag are registered into db_key/db_flag, and the granted port ID is recorded.
  - Latency: db_valid rises the cycle after the req handshake.
- ISSUE -> IDLE: on db_valid && db_ready.
  - Push the port ID into the tag FIFO and update the last-grant pointer.
  - No new grant in the same cycle, so at most one request per 2 cycles.
- Never grant while outstanding == TAG_DEPTH; both req_ready outputs stay 0 until a response pops a tag.
- Response path, on db_out_valid:
  - Pop the FIFO head; in the next cycle assert rsp<head>_valid=1 with rsp<head>_flag=db_out_flag (1-cycle latency).
  - The other port's rsp_valid stays 0.
  - rspN_flag holds its value when rspN_valid=0.
- Push and pop in the same cycle: count unchanged; pointers advance independently and wrap modulo TAG_DEPTH.
- db_out_valid with an empty FIFO: response dropped, no rsp strobe, err_orphan set to 1. err_orphan clears only on reset.
- outstanding = FIFO count, updated the cycle after the push/pop edge.
- Requesters must hold reqN_valid, key and flag until they see reqN_ready. A requester dropping valid without a handshake is legal and has no effect.
- Reset while in ISSUE or with tags outstanding:
  - db_valid drops the next cycle and tags are discarded.
  - Responses arriving afterwards count as orphans.

Optional Feature:
- Macro KVS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins when both are valid, and the last-grant pointer is not implemented.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Single request: req0 key=96'h1, flag=4'h1, db_ready=1 → req0_ready 1 cycle, db_valid the next cycle with key 96'h1, outstanding=1. Then db_out_flag=4'h3 → rsp0_valid with flag 4'h3 one cycle later, outstanding=0.
- Both ports valid continuously, responses returned immediately → grants alternate 0,1,0,1 (round-robin build); with KVS_ARB_FIXED_PRIO_EN, port 1 is never granted.
- db_ready held 0 for 5 cycles while in ISSUE → db_key/db_flag stable, no req_ready; accept on cycle 6 → outstanding increments exactly once.
- 8 requests with no responses → outstanding=8 and req_ready stays 0. One db_out_valid → outstanding=7 and the next grant follows. A push and pop in the same cycle keeps the count.
- Interleaved issue order 0,1,1,0 with responses in order → rsp strobes on ports 0,1,1,0 with matching flags.
- db_out_valid with an empty FIFO → no rsp strobe, err_orphan=1 and held. rst_n=0 for 1 cycle mid-ISSUE → db_valid=0, outstanding=0, err_orphan=0.
